// File: rtl/cp0_ctrl_pkg.sv
// Shared MIPS definitions: CP0 register numbers, exception codes and CP0 field positions.
package mips_defs;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    localparam int SR_IM_LO     = 10;
    localparam int SR_EXL       = 1;
    localparam int SR_IE        = 0;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_LO = 2;

    function automatic logic irq_pending(input logic [5:0] hw_int,
                                         input logic [5:0] im,
                                         input logic       ie,
                                         input logic       exl);
        return (|(hw_int & im)) & ie & ~exl;
    endfunction

endpackage

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception/interrupt controller: captures M-stage exceptions and
// interrupts, holds SR/Cause/EPC/PrID and serves mfc0/mtc0.
module cp0_ctrl
    import mips_defs::*;
#(
    parameter logic [31:0] PRID = 32'h0000_4D49
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_code_m,
    input  logic [5:0]  hw_int,
    input  logic        eret_m,
    output logic        int_req,
    output logic [29:0] epc_out,
    output logic        exl
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_irq;
    logic        w_exc;
    logic [31:0] w_epc_next;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    assign w_irq   = irq_pending(hw_int, r_im, r_ie, r_exl);
    assign w_exc   = (exc_code_m != 5'd0) & ~r_exl;
    assign int_req = w_irq | w_exc;

    // A delay-slot instruction returns to its branch so the branch re-executes.
    assign w_epc_next = (bd_m ? (pc_m - 32'd4) : pc_m) & ~32'h3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= '0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else begin
            r_ip <= hw_int;
            if (int_req) begin
                r_exl      <= 1'b1;
                r_exc_code <= w_irq ? EXC_INT : exc_code_m;
                r_bd       <= bd_m;
                r_epc      <= w_epc_next;
            end else if (eret_m) begin
                r_exl <= 1'b0;
            end else if (we) begin
                case (addr)
                    CP0_SR: begin
                        r_im  <= wdata[SR_IM_LO +: 6];
                        r_exl <= wdata[SR_EXL];
                        r_ie  <= wdata[SR_IE];
                    end
                    CP0_EPC: r_epc <= {wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_sr                          = '0;
        w_sr[SR_IM_LO +: 6]           = r_im;
        w_sr[SR_EXL]                  = r_exl;
        w_sr[SR_IE]                   = r_ie;
        w_cause                       = '0;
        w_cause[CAUSE_BD]             = r_bd;
        w_cause[CAUSE_IP_LO +: 6]     = r_ip;
        w_cause[CAUSE_EXC_LO +: 5]    = r_exc_code;
        case (addr)
            CP0_SR:    rdata = w_sr;
            CP0_CAUSE: rdata = w_cause;
            CP0_EPC:   rdata = r_epc;
            CP0_PRID:  rdata = PRID;
            default:   rdata = '0;
        endcase
    end

    assign epc_out = r_epc[31:2];
    assign exl     = r_exl;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: stimulus queues expected observations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic [5:0]  hw_int;
    logic        eret_m;
    logic        int_req;
    logic [29:0] epc_out;
    logic        exl;

    localparam int SEL_RDATA = 0;
    localparam int SEL_INTREQ = 1;
    localparam int SEL_EXL = 2;
    localparam int SEL_EPCOUT = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    cp0_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .pc_m       (pc_m),
        .bd_m       (bd_m),
        .exc_code_m (exc_code_m),
        .hw_int     (hw_int),
        .eret_m     (eret_m),
        .int_req    (int_req),
        .epc_out    (epc_out),
        .exl        (exl)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation queued during a cycle is checked at that cycle's negedge.
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                c = q.pop_front();
                case (c.sel)
                    SEL_RDATA:  act = rdata;
                    SEL_INTREQ: act = {31'd0, int_req};
                    SEL_EXL:    act = {31'd0, exl};
                    default:    act = {2'b00, epc_out};
                endcase
                n_tests++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int sel, input logic [31:0] v);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] v);
        addr = a;
        chk(name, SEL_RDATA, v);
        cyc();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        cyc();
        we    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; pc_m = '0;
        bd_m = 1'b0; exc_code_m = '0; hw_int = '0; eret_m = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset read-back
        chk("rst_int_req", SEL_INTREQ, 32'd0);
        chk("rst_exl", SEL_EXL, 32'd0);
        chk("rst_epc_out", SEL_EPCOUT, 32'd0);
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h0000_4D49);

        // Interrupt entry
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_written", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; pc_m = 32'h3010; bd_m = 1'b0;
        chk("irq_int_req", SEL_INTREQ, 32'd1);
        cyc();
        chk("irq_masked_next", SEL_INTREQ, 32'd0);
        chk("irq_exl", SEL_EXL, 32'd1);
        rd("irq_cause", 5'd13, 32'h0000_0400);
        hw_int = 6'b0;
        chk("irq_epc_out", SEL_EPCOUT, 32'h0000_0C04);
        rd("irq_epc", 5'd14, 32'h0000_3010);

        // Masked while EXL
        exc_code_m = 5'd4;
        chk("exl_mask_int_req", SEL_INTREQ, 32'd0);
        rd("exl_mask_cause_pre", 5'd13, 32'h0);
        exc_code_m = 5'd0;
        rd("exl_mask_cause", 5'd13, 32'h0);
        eret_m = 1'b1;
        cyc();
        eret_m = 1'b0;
        chk("eret_exl", SEL_EXL, 32'd0);
        chk("eret_epc_out", SEL_EPCOUT, 32'h0000_0C04);
        chk("eret_int_req", SEL_INTREQ, 32'd0);
        rd("eret_sr", 5'd12, 32'h0000_0401);

        // Delay-slot exception
        exc_code_m = 5'd12; bd_m = 1'b1; pc_m = 32'h3024;
        chk("ds_int_req", SEL_INTREQ, 32'd1);
        cyc();
        exc_code_m = 5'd0; bd_m = 1'b0;
        rd("ds_cause", 5'd13, 32'h8000_0030);
        chk("ds_exl", SEL_EXL, 32'd1);
        rd("ds_epc", 5'd14, 32'h0000_3020);
        eret_m = 1'b1;
        cyc();
        eret_m = 1'b0;

        // Re-assertion after eret with the line still held
        hw_int = 6'b000001; pc_m = 32'h4000;
        chk("re_int_req", SEL_INTREQ, 32'd1);
        cyc();
        chk("re_masked", SEL_INTREQ, 32'd0);
        eret_m = 1'b1;
        chk("re_eret_cycle", SEL_INTREQ, 32'd0);
        cyc();
        eret_m = 1'b0;

        // Simultaneous interrupt, exception and mtc0 EPC
        exc_code_m = 5'd10; pc_m = 32'h3040; bd_m = 1'b0;
        we = 1'b1; addr = 5'd14; wdata = 32'h5000;
        chk("re_assert", SEL_INTREQ, 32'd1);
        cyc();
        we = 1'b0; exc_code_m = 5'd0; hw_int = 6'b0;
        rd("sim_cause", 5'd13, 32'h0000_0400);
        rd("sim_epc", 5'd14, 32'h0000_3040);
        chk("sim_exl", SEL_EXL, 32'd1);

        // Software EPC write, read-only PrID, unmapped register
        mtc0(5'd14, 32'h1234_5677);
        chk("mtc0_epc_out", SEL_EPCOUT, 32'h048D_159D);
        rd("mtc0_epc", 5'd14, 32'h1234_5674);
        mtc0(5'd15, 32'hFFFF_FFFF);
        rd("prid_ro", 5'd15, 32'h0000_4D49);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0);
        rd("unmapped", 5'd3, 32'h0);

        // Reset inside the handler
        mtc0(5'd14, 32'h3010);
        rd("pre_rst_epc", 5'd14, 32'h3010);
        hw_int = 6'b000001;
        reset = 1'b1;
        cyc();
        reset = 1'b0; hw_int = 6'b0;
        chk("hrst_exl", SEL_EXL, 32'd0);
        chk("hrst_int_req", SEL_INTREQ, 32'd0);
        chk("hrst_epc_out", SEL_EPCOUT, 32'd0);
        rd("hrst_sr", 5'd12, 32'h0);
        rd("hrst_cause", 5'd13, 32'h0);
        rd("hrst_epc", 5'd14, 32'h0);

        for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
